// File: rtl/retire_commit_if.sv
// Retire-stage bundle: two retiring ROB slots, register-file and free-list
// write-backs, store write request channel, and status outputs.
interface retire_commit_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PREG_W = 6
);
    logic              in1_valid;
    logic [DATA_W-1:0] in1_pc;
    logic [PREG_W-1:0] in1_rd;
    logic [PREG_W-1:0] in1_rd_old;
    logic [DATA_W-1:0] in1_result;
    logic [DATA_W-1:0] in1_mem_data;
    logic              in1_regwrite;
    logic              in1_memwrite;

    logic              in2_valid;
    logic [DATA_W-1:0] in2_pc;
    logic [PREG_W-1:0] in2_rd;
    logic [PREG_W-1:0] in2_rd_old;
    logic [DATA_W-1:0] in2_result;
    logic [DATA_W-1:0] in2_mem_data;
    logic              in2_regwrite;
    logic              in2_memwrite;

    logic              rf1_we;
    logic [PREG_W-1:0] rf1_waddr;
    logic [DATA_W-1:0] rf1_wdata;
    logic              rf2_we;
    logic [PREG_W-1:0] rf2_waddr;
    logic [DATA_W-1:0] rf2_wdata;

    logic              free1_valid;
    logic [PREG_W-1:0] free1_reg;
    logic              free2_valid;
    logic [PREG_W-1:0] free2_reg;

    logic              mem_wvalid;
    logic [DATA_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wready;

    logic [1:0]        retire_count;
    logic              sb_overflow;

    modport master (
        output in1_valid, in1_pc, in1_rd, in1_rd_old, in1_result, in1_mem_data,
               in1_regwrite, in1_memwrite,
               in2_valid, in2_pc, in2_rd, in2_rd_old, in2_result, in2_mem_data,
               in2_regwrite, in2_memwrite,
               mem_wready,
        input  rf1_we, rf1_waddr, rf1_wdata, rf2_we, rf2_waddr, rf2_wdata,
               free1_valid, free1_reg, free2_valid, free2_reg,
               mem_wvalid, mem_waddr, mem_wdata, retire_count, sb_overflow
    );

    modport slave (
        input  in1_valid, in1_pc, in1_rd, in1_rd_old, in1_result, in1_mem_data,
               in1_regwrite, in1_memwrite,
               in2_valid, in2_pc, in2_rd, in2_rd_old, in2_result, in2_mem_data,
               in2_regwrite, in2_memwrite,
               mem_wready,
        output rf1_we, rf1_waddr, rf1_wdata, rf2_we, rf2_waddr, rf2_wdata,
               free1_valid, free1_reg, free2_valid, free2_reg,
               mem_wvalid, mem_waddr, mem_wdata, retire_count, sb_overflow
    );
endinterface

// File: rtl/retire_commit.sv
// Dual-slot retire/commit: register write-back, old-preg release and an in-order store buffer.
// Define RETIRE_PERF_EN to add the perf_retired / perf_sb_stall counters.
module retire_commit #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned PREG_W   = 6,
    parameter int unsigned SB_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    retire_commit_if.slave   bus
`ifdef RETIRE_PERF_EN
    ,
    output logic [31:0]      o_perf_retired,
    output logic [31:0]      o_perf_sb_stall
`endif
);
    localparam int unsigned PTR_W = $clog2(SB_DEPTH);
    localparam int unsigned CNT_W = $clog2(SB_DEPTH + 1);

    logic [DATA_W-1:0] r_sb_addr [SB_DEPTH];
    logic [DATA_W-1:0] r_sb_data [SB_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              r_rf1_we;
    logic [PREG_W-1:0] r_rf1_waddr;
    logic [DATA_W-1:0] r_rf1_wdata;
    logic              r_rf2_we;
    logic [PREG_W-1:0] r_rf2_waddr;
    logic [DATA_W-1:0] r_rf2_wdata;
    logic              r_free1_valid;
    logic [PREG_W-1:0] r_free1_reg;
    logic              r_free2_valid;
    logic [PREG_W-1:0] r_free2_reg;
    logic [1:0]        r_retire_count;
    logic              r_sb_overflow;

    logic              w_acc1, w_acc2;
    logic              w_deq;
    logic [CNT_W-1:0]  w_space;
    logic              w_st1, w_st2;
    logic              w_ok1, w_ok2;
    logic              w_drop;
    logic [PTR_W-1:0]  w_wr_ptr2;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_conflict;
    logic              w_rf1_we, w_rf2_we;
    logic              w_free1, w_free2;
    logic [1:0]        w_retire;
    logic              w_unused_pc;

    assign w_unused_pc = ^{bus.in1_pc, bus.in2_pc};

    always_comb begin
        w_acc1      = bus.in1_valid;
        w_acc2      = bus.in1_valid & bus.in2_valid;
        w_deq       = (r_count != '0) & bus.mem_wready;
        // A slot freed by this cycle's dequeue is reusable by this cycle's enqueue.
        w_space     = CNT_W'(SB_DEPTH) - r_count + CNT_W'(w_deq);
        w_st1       = w_acc1 & bus.in1_memwrite;
        w_st2       = w_acc2 & bus.in2_memwrite;
        w_ok1       = w_st1 & (w_space != '0);
        w_ok2       = w_st2 & (w_space > CNT_W'(w_ok1));
        w_drop      = (w_st1 & ~w_ok1) | (w_st2 & ~w_ok2);
        w_wr_ptr2   = r_wr_ptr + PTR_W'(w_ok1);
        w_count_nxt = r_count + CNT_W'(w_ok1) + CNT_W'(w_ok2) - CNT_W'(w_deq);
        w_conflict  = w_acc2 & bus.in1_regwrite & bus.in2_regwrite
                      & (bus.in1_rd == bus.in2_rd);
        w_rf1_we    = w_acc1 & bus.in1_regwrite & ~w_conflict;
        w_rf2_we    = w_acc2 & bus.in2_regwrite;
        w_free1     = w_acc1 & bus.in1_regwrite & (bus.in1_rd_old != '0);
        w_free2     = w_acc2 & bus.in2_regwrite & (bus.in2_rd_old != '0);
        w_retire    = {1'b0, w_acc1} + {1'b0, w_acc2};
    end

    // Storage needs no reset: validity is tracked entirely by r_count.
    always_ff @(posedge i_clk) begin
        if (w_ok1) begin
            r_sb_addr[r_wr_ptr] <= bus.in1_result;
            r_sb_data[r_wr_ptr] <= bus.in1_mem_data;
        end
        if (w_ok2) begin
            r_sb_addr[w_wr_ptr2] <= bus.in2_result;
            r_sb_data[w_wr_ptr2] <= bus.in2_mem_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_rd_ptr       <= '0;
            r_wr_ptr       <= '0;
            r_count        <= '0;
            r_rf1_we       <= 1'b0;
            r_rf1_waddr    <= '0;
            r_rf1_wdata    <= '0;
            r_rf2_we       <= 1'b0;
            r_rf2_waddr    <= '0;
            r_rf2_wdata    <= '0;
            r_free1_valid  <= 1'b0;
            r_free1_reg    <= '0;
            r_free2_valid  <= 1'b0;
            r_free2_reg    <= '0;
            r_retire_count <= 2'd0;
            r_sb_overflow  <= 1'b0;
        end else begin
            r_rd_ptr       <= r_rd_ptr + PTR_W'(w_deq);
            r_wr_ptr       <= r_wr_ptr + PTR_W'(w_ok1) + PTR_W'(w_ok2);
            r_count        <= w_count_nxt;
            r_rf1_we       <= w_rf1_we;
            r_rf1_waddr    <= bus.in1_rd;
            r_rf1_wdata    <= bus.in1_result;
            r_rf2_we       <= w_rf2_we;
            r_rf2_waddr    <= bus.in2_rd;
            r_rf2_wdata    <= bus.in2_result;
            r_free1_valid  <= w_free1;
            r_free1_reg    <= bus.in1_rd_old;
            r_free2_valid  <= w_free2;
            r_free2_reg    <= bus.in2_rd_old;
            r_retire_count <= w_retire;
            r_sb_overflow  <= r_sb_overflow | w_drop;
        end
    end

    assign bus.rf1_we       = r_rf1_we;
    assign bus.rf1_waddr    = r_rf1_waddr;
    assign bus.rf1_wdata    = r_rf1_wdata;
    assign bus.rf2_we       = r_rf2_we;
    assign bus.rf2_waddr    = r_rf2_waddr;
    assign bus.rf2_wdata    = r_rf2_wdata;
    assign bus.free1_valid  = r_free1_valid;
    assign bus.free1_reg    = r_free1_reg;
    assign bus.free2_valid  = r_free2_valid;
    assign bus.free2_reg    = r_free2_reg;
    assign bus.mem_wvalid   = (r_count != '0);
    assign bus.mem_waddr    = r_sb_addr[r_rd_ptr];
    assign bus.mem_wdata    = r_sb_data[r_rd_ptr];
    assign bus.retire_count = r_retire_count;
    assign bus.sb_overflow  = r_sb_overflow;

`ifdef RETIRE_PERF_EN
    logic [31:0] r_perf_retired;
    logic [31:0] r_perf_sb_stall;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_perf_retired  <= '0;
            r_perf_sb_stall <= '0;
        end else begin
            r_perf_retired  <= r_perf_retired + 32'(r_retire_count);
            r_perf_sb_stall <= r_perf_sb_stall
                               + 32'((r_count != '0) & ~bus.mem_wready);
        end
    end

    assign o_perf_retired  = r_perf_retired;
    assign o_perf_sb_stall = r_perf_sb_stall;
`endif
endmodule

// File: tb/tb_retire_commit.sv
// Directed bench for retire_commit: vector table for retire write-back plus
// hand-written store-buffer sequences (ordering, overflow, full+drain, reset).
module tb_retire_commit;
    logic clk;
    logic rst_n;
    int   n_run;
    int   n_fail;

    retire_commit_if #(.DATA_W(32), .PREG_W(6)) bus ();

`ifdef RETIRE_PERF_EN
    logic [31:0] perf_retired;
    logic [31:0] perf_sb_stall;
`endif

    retire_commit #(
        .DATA_W   (32),
        .PREG_W   (6),
        .SB_DEPTH (4)
    ) dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .bus             (bus.slave)
`ifdef RETIRE_PERF_EN
        ,
        .o_perf_retired  (perf_retired),
        .o_perf_sb_stall (perf_sb_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v1;
        logic        rw1;
        logic [5:0]  rd1;
        logic [5:0]  old1;
        logic [31:0] res1;
        logic        v2;
        logic        rw2;
        logic [5:0]  rd2;
        logic [5:0]  old2;
        logic [31:0] res2;
        logic        e_we1;
        logic [5:0]  e_wa1;
        logic [31:0] e_wd1;
        logic        e_we2;
        logic [5:0]  e_wa2;
        logic [31:0] e_wd2;
        logic        e_fv1;
        logic [5:0]  e_fr1;
        logic        e_fv2;
        logic [5:0]  e_fr2;
        logic [1:0]  e_rc;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.in1_valid = 1'b0; bus.in1_pc = '0; bus.in1_rd = '0; bus.in1_rd_old = '0;
        bus.in1_result = '0; bus.in1_mem_data = '0; bus.in1_regwrite = 1'b0;
        bus.in1_memwrite = 1'b0;
        bus.in2_valid = 1'b0; bus.in2_pc = '0; bus.in2_rd = '0; bus.in2_rd_old = '0;
        bus.in2_result = '0; bus.in2_mem_data = '0; bus.in2_regwrite = 1'b0;
        bus.in2_memwrite = 1'b0;
    endtask

    task automatic drive_st1(input logic [31:0] a, input logic [31:0] d);
        clear_in();
        bus.in1_valid = 1'b1; bus.in1_memwrite = 1'b1;
        bus.in1_result = a; bus.in1_mem_data = d;
    endtask

    task automatic drive_st2(input logic [31:0] a1, input logic [31:0] d1,
                             input logic [31:0] a2, input logic [31:0] d2);
        drive_st1(a1, d1);
        bus.in2_valid = 1'b1; bus.in2_memwrite = 1'b1;
        bus.in2_result = a2; bus.in2_mem_data = d2;
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.mem_wready = 1'b0;
        clear_in();

        vecs[0] = '{1'b1, 1'b1, 6'd5, 6'd12, 32'h11, 1'b1, 1'b1, 6'd7, 6'd0, 32'h22,
                    1'b1, 6'd5, 32'h11, 1'b1, 6'd7, 32'h22, 1'b1, 6'd12, 1'b0, 6'd0, 2'd2};
        vecs[1] = '{1'b0, 1'b1, 6'd3, 6'd4, 32'h33, 1'b1, 1'b1, 6'd8, 6'd9, 32'h44,
                    1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 1'b0, 6'd0, 2'd0};
        vecs[2] = '{1'b1, 1'b1, 6'd9, 6'd0, 32'hA, 1'b1, 1'b1, 6'd9, 6'd0, 32'hB,
                    1'b0, 6'd0, 32'h0, 1'b1, 6'd9, 32'hB, 1'b0, 6'd0, 1'b0, 6'd0, 2'd2};
        vecs[3] = '{1'b1, 1'b1, 6'd4, 6'd20, 32'h55, 1'b0, 1'b1, 6'd6, 6'd7, 32'h66,
                    1'b1, 6'd4, 32'h55, 1'b0, 6'd0, 32'h0, 1'b1, 6'd20, 1'b0, 6'd0, 2'd1};
        vecs[4] = '{1'b1, 1'b0, 6'd10, 6'd11, 32'h77, 1'b1, 1'b0, 6'd12, 6'd13, 32'h88,
                    1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 1'b0, 6'd0, 2'd2};
        vecs[5] = '{1'b1, 1'b0, 6'd14, 6'd15, 32'h99, 1'b1, 1'b1, 6'd16, 6'd33, 32'hAA,
                    1'b0, 6'd0, 32'h0, 1'b1, 6'd16, 32'hAA, 1'b0, 6'd0, 1'b1, 6'd33, 2'd2};
        vecs[6] = '{1'b1, 1'b1, 6'd9, 6'd21, 32'hA, 1'b1, 1'b0, 6'd9, 6'd22, 32'hB,
                    1'b1, 6'd9, 32'hA, 1'b0, 6'd0, 32'h0, 1'b1, 6'd21, 1'b0, 6'd0, 2'd2};

        // Reset state, with a retiring store presented during reset.
        drive_st1(32'h900, 32'h9);
        bus.in1_regwrite = 1'b1; bus.in1_rd = 6'd1; bus.in1_rd_old = 6'd2;
        tick();
        tick();
        clear_in();
        chk("rst_rf1_we", 32'(bus.rf1_we), 32'd0);
        chk("rst_rf2_we", 32'(bus.rf2_we), 32'd0);
        chk("rst_free1", 32'(bus.free1_valid), 32'd0);
        chk("rst_free2", 32'(bus.free2_valid), 32'd0);
        chk("rst_wvalid", 32'(bus.mem_wvalid), 32'd0);
        chk("rst_retire", 32'(bus.retire_count), 32'd0);
        chk("rst_ovf", 32'(bus.sb_overflow), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_discard", 32'(bus.mem_wvalid), 32'd0);

        for (int i = 0; i < 7; i++) begin
            clear_in();
            bus.in1_valid = vecs[i].v1; bus.in1_regwrite = vecs[i].rw1;
            bus.in1_rd = vecs[i].rd1; bus.in1_rd_old = vecs[i].old1;
            bus.in1_result = vecs[i].res1;
            bus.in2_valid = vecs[i].v2; bus.in2_regwrite = vecs[i].rw2;
            bus.in2_rd = vecs[i].rd2; bus.in2_rd_old = vecs[i].old2;
            bus.in2_result = vecs[i].res2;
            tick();
            clear_in();
            chk($sformatf("v%0d_rf1_we", i), 32'(bus.rf1_we), 32'(vecs[i].e_we1));
            if (vecs[i].e_we1) begin
                chk($sformatf("v%0d_rf1_waddr", i), 32'(bus.rf1_waddr), 32'(vecs[i].e_wa1));
                chk($sformatf("v%0d_rf1_wdata", i), bus.rf1_wdata, vecs[i].e_wd1);
            end
            chk($sformatf("v%0d_rf2_we", i), 32'(bus.rf2_we), 32'(vecs[i].e_we2));
            if (vecs[i].e_we2) begin
                chk($sformatf("v%0d_rf2_waddr", i), 32'(bus.rf2_waddr), 32'(vecs[i].e_wa2));
                chk($sformatf("v%0d_rf2_wdata", i), bus.rf2_wdata, vecs[i].e_wd2);
            end
            chk($sformatf("v%0d_free1", i), 32'(bus.free1_valid), 32'(vecs[i].e_fv1));
            if (vecs[i].e_fv1)
                chk($sformatf("v%0d_free1_reg", i), 32'(bus.free1_reg), 32'(vecs[i].e_fr1));
            chk($sformatf("v%0d_free2", i), 32'(bus.free2_valid), 32'(vecs[i].e_fv2));
            if (vecs[i].e_fv2)
                chk($sformatf("v%0d_free2_reg", i), 32'(bus.free2_reg), 32'(vecs[i].e_fr2));
            chk($sformatf("v%0d_retire", i), 32'(bus.retire_count), 32'(vecs[i].e_rc));
        end
        tick();

        // Store ordering with memory always ready.
        bus.mem_wready = 1'b1;
        drive_st2(32'h100, 32'h1, 32'h104, 32'h2);
        chk("ord_not_early", 32'(bus.mem_wvalid), 32'd0);
        tick();
        clear_in();
        chk("ord_v0", 32'(bus.mem_wvalid), 32'd1);
        chk("ord_a0", bus.mem_waddr, 32'h100);
        chk("ord_d0", bus.mem_wdata, 32'h1);
        chk("ord_retire", 32'(bus.retire_count), 32'd2);
        tick();
        chk("ord_v1", 32'(bus.mem_wvalid), 32'd1);
        chk("ord_a1", bus.mem_waddr, 32'h104);
        chk("ord_d1", bus.mem_wdata, 32'h2);
        tick();
        chk("ord_empty", 32'(bus.mem_wvalid), 32'd0);

        // Overflow: five stores into four entries while memory stalls.
        bus.mem_wready = 1'b0;
        drive_st2(32'h200, 32'h10, 32'h204, 32'h11);
        tick();
        drive_st2(32'h208, 32'h12, 32'h20C, 32'h13);
        tick();
        chk("ovf_before", 32'(bus.sb_overflow), 32'd0);
        drive_st1(32'h210, 32'h14);
        tick();
        clear_in();
        chk("ovf_set", 32'(bus.sb_overflow), 32'd1);
        repeat (3) tick();
        chk("ovf_sticky", 32'(bus.sb_overflow), 32'd1);
        chk("ovf_stable_a", bus.mem_waddr, 32'h200);
        chk("ovf_stable_d", bus.mem_wdata, 32'h10);
        bus.mem_wready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_v", i), 32'(bus.mem_wvalid), 32'd1);
            chk($sformatf("drain%0d_a", i), bus.mem_waddr, 32'h200 + 32'(4 * i));
            chk($sformatf("drain%0d_d", i), bus.mem_wdata, 32'h10 + 32'(i));
            tick();
        end
        chk("drain_done", 32'(bus.mem_wvalid), 32'd0);
        chk("drain_ovf", 32'(bus.sb_overflow), 32'd1);

        // Reset mid-drain flushes pending stores and the sticky error.
        bus.mem_wready = 1'b0;
        drive_st2(32'h400, 32'h40, 32'h404, 32'h41);
        tick();
        drive_st1(32'h408, 32'h42);
        tick();
        clear_in();
        chk("mid_queued", 32'(bus.mem_wvalid), 32'd1);
        rst_n = 1'b0;
        drive_st1(32'h500, 32'h50);
        bus.in1_regwrite = 1'b1; bus.in1_rd = 6'd3; bus.in1_rd_old = 6'd4;
        tick();
        rst_n = 1'b1;
        clear_in();
        chk("mid_wvalid", 32'(bus.mem_wvalid), 32'd0);
        chk("mid_ovf", 32'(bus.sb_overflow), 32'd0);
        chk("mid_retire", 32'(bus.retire_count), 32'd0);
        chk("mid_rf1_we", 32'(bus.rf1_we), 32'd0);
        chk("mid_free1", 32'(bus.free1_valid), 32'd0);
        bus.mem_wready = 1'b1;
        tick();
        chk("mid_after", 32'(bus.mem_wvalid), 32'd0);

        // Full buffer accepts a store in the same cycle the head drains.
        bus.mem_wready = 1'b0;
        drive_st2(32'h300, 32'h30, 32'h304, 32'h31);
        tick();
        drive_st2(32'h308, 32'h32, 32'h30C, 32'h33);
        tick();
        bus.mem_wready = 1'b1;
        drive_st1(32'h310, 32'h34);
        tick();
        clear_in();
        chk("full_swap_ovf", 32'(bus.sb_overflow), 32'd0);
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("full%0d_a", i), bus.mem_waddr, 32'h300 + 32'(4 * i));
            chk($sformatf("full%0d_d", i), bus.mem_wdata, 32'h30 + 32'(i));
            tick();
        end
        chk("full_empty", 32'(bus.mem_wvalid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/retire_commit.md
RETIRE_COMMIT -- requirements
Module: retire_commit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of result, mem_data, PC and store address.
REQ-002 SHALL have parameter PREG_W, default 6, physical register index width.
REQ-003 SHALL have parameter SB_DEPTH, default 4, store buffer entries (power of 2, at least 2).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  reset, synchronous, active-low.
REQ-006 inN_valid / inN_pc / inN_rd / inN_rd_old / inN_result / inN_mem_data / inN_regwrite / inN_memwrite  in  1/DATA_W/PREG_W/PREG_W/DATA_W/DATA_W/1/1  retiring ROB entry, slots N=1,2, slot 1 oldest.
REQ-007 rfN_we / rfN_waddr / rfN_wdata  out  1/PREG_W/DATA_W  register-file write ports, N=1,2.
REQ-008 freeN_valid / freeN_reg  out  1/PREG_W  old physical register released to the free list, N=1,2.
REQ-009 mem_wvalid / mem_waddr / mem_wdata  out  1/DATA_W/DATA_W  store write request.
REQ-010 mem_wready  in  1  memory accepts the store request.
REQ-011 retire_count  out  2  instructions accepted in the previous cycle (0..2).
REQ-012 sb_overflow  out  1  sticky error: a store was dropped.

Function
REQ-013 Slot 1 SHALL be accepted when in1_valid=1.
REQ-014 Slot 2 SHALL be accepted only when in1_valid=1 and in2_valid=1; otherwise slot 2 SHALL be ignored.
REQ-015 For each accepted slot with regwrite=1, the cycle after acceptance SHALL assert rfN_we=1, rfN_waddr=rd and rfN_wdata=result.
REQ-016 If both slots write the same rd in the same cycle, rf1_we SHALL be suppressed and slot 2 wins.
REQ-017 For each accepted slot with regwrite=1 and rd_old!=0, the cycle after acceptance SHALL assert freeN_valid=1 and freeN_reg=rd_old.
REQ-018 Each accepted slot with memwrite=1 SHALL enqueue {addr=result, data=mem_data} into the store FIFO, with slot 1 enqueued before slot 2.
REQ-019 mem_wvalid SHALL equal "FIFO not empty", and mem_waddr/mem_wdata SHALL present the FIFO head.
REQ-020 The head SHALL dequeue when mem_wvalid=1 and mem_wready=1.
REQ-021 A store enqueued in cycle n SHALL be visible on mem_wvalid no earlier than cycle n+1.
REQ-022 Free space for enqueue SHALL be computed as SB_DEPTH - count + (dequeue this cycle ? 1 : 0).
REQ-023 When space is insufficient, slot 1 SHALL take priority; each store that finds no space SHALL be dropped and SHALL set sb_overflow=1 until reset.
REQ-024 The request held by an unaccepted head SHALL remain stable while mem_wready=0.
REQ-025 Read and write pointers SHALL wrap modulo SB_DEPTH, with a separate occupancy count distinguishing full from empty.
REQ-026 retire_count SHALL be registered, and the block SHALL have no input backpressure; every valid input SHALL be processed in its arrival cycle.

Reset
REQ-027 When reset=0 at a rising edge, the block SHALL clear all rf*_we, free*_valid, mem_wvalid, retire_count, sb_overflow, FIFO pointers and count.
REQ-028 Inputs presented during reset SHALL be discarded.
REQ-029 Reset asserted mid-drain SHALL flush all pending stores, and mem_wvalid SHALL be 0 in the cycle after reset.

Configuration
REQ-030 When RETIRE_PERF_EN is defined, the block SHALL add outputs perf_retired (32-bit, +retire_count each cycle, wrapping) and perf_sb_stall (32-bit, +1 each cycle with mem_wvalid=1 and mem_wready=0), both reset to 0.
REQ-031 When RETIRE_PERF_EN is undefined, those ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-032 Dual ALU retire: slot1 {rd=5, rd_old=12, result=0x11, regwrite=1}, slot2 {rd=7, rd_old=0, result=0x22, regwrite=1} -> next cycle rf1 writes 5←0x11, rf2 writes 7←0x22, free1_valid=1 with reg 12, free2_valid=0, retire_count=2.
REQ-033 in1_valid=0, in2_valid=1 -> no writes, no frees, retire_count=0.
REQ-034 Same-rd conflict: both slots rd=9, results 0xA and 0xB -> only rf2_we=1 with 0xB.
REQ-035 Store ordering: two stores in one cycle, slot1 {addr=0x100, data=1}, slot2 {addr=0x104, data=2}, mem_wready=1 -> mem_waddr 0x100 then 0x104 on consecutive cycles.
REQ-036 Overflow: mem_wready=0, 5 stores with SB_DEPTH=4 -> fifth dropped, sb_overflow=1 and stays 1; raising mem_wready drains exactly 4 stores in order.
REQ-037 Reset mid-drain: 3 stores queued, reset=0 for one cycle -> mem_wvalid=0, sb_overflow=0, retire_count=0 on the following cycle.
